clk_gen_multi: RTL and testbench
================================

Name: clk_gen_multi

Overview:
- Multi-channel, gated, programmable clock-enable generator; successor to the single fixed-rate gated clock source.
- Each of CHANNELS channels produces a 50%-duty divided waveform of the system clock, gated by its own valid.
- Guarantees no truncated pulses on start/stop and supports phase-aligned restart of all channels.
- Feeds bench stimulus and slow-peripheral enables. All outputs are registered, in the clk domain; they are never used as real clock nets.

Parameters:
- CHANNELS, 4, number of independent channels.
- DIV_W, 8, width of each channel's half-period field.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- valid  input  CHANNELS  per-channel run request; bit i gates channel i.
- half_period  input  CHANNELS*DIV_W  channel i half-period in clk cycles, bits [i*DIV_W +: DIV_W]; 0 treated as 1.
- sync_start  input  1  one-cycle pulse; phase-aligns all requesting channels.
- c  output  CHANNELS  divided waveform per channel.
- rise  output  CHANNELS  one-cycle strobe, asserted in the first cycle c[i] is 1.
- fall  output  CHANNELS  one-cycle strobe, asserted in the first cycle c[i] is 0 after a high phase.
- running  output  CHANNELS  1 while channel i is not IDLE.

Behaviour:
- Reset (rst_n=0 at a rising edge): all channels enter IDLE; c=0, rise=0, fall=0, running=0; counters and latched divisor cleared. Reset overrides everything, including mid-phase.
- Per-channel state: IDLE, HIGH, LOW. Registers: cnt [DIV_W-1:0] and hp_lat [DIV_W-1:0], where hp_lat = (half_period==0) ? 1 : half_period.
- Divisor latch: hp_lat is loaded only on entry to HIGH. A half_period change mid-period takes effect at the next HIGH entry.
- IDLE:
  - If valid[i]=1 at edge t, then at edge t+1: state=HIGH, c=1, rise=1, running=1, cnt=0.
  - Start latency is 1 clk.
- HIGH:
  - If cnt==hp_lat-1: go to LOW, c=0, fall=1, cnt=0.
  - Otherwise cnt+1.
  - A high phase always lasts exactly hp_lat cycles.
- LOW:
  - If cnt==hp_lat-1: if valid[i]=1, go to HIGH (rise=1, reload hp_lat); otherwise go to IDLE (running=0).
  - Otherwise cnt+1.
  - A low phase always lasts exactly hp_lat cycles.
- Steady state: period 2*hp_lat, duty exactly 50%. With half_period=1 (or 0), c toggles every cycle.
- Stop: valid dropping in any phase never truncates the current phase. The channel completes the current HIGH phase and the following LOW phase, then goes IDLE.
  - Worst-case stop latency: 2*hp_lat cycles.
  - valid reasserting before LOW completes means no IDLE gap.
- sync_start=1 at edge t: every channel with valid[i]=1 is forced at t+1 to HIGH with cnt=0, hp_lat reloaded.
  - rise[i]=1 only if c[i] was 0 before the edge; a channel already high restarts its high phase without a rise strobe.
  - This may shorten the current phase; that is permitted and only occurs on sync_start.
  - Channels with valid[i]=0 are unaffected.
  - Priority order: rst_n > sync_start > normal sequencing.
- rise and fall are never both 1 on one channel in the same cycle. Channels are fully independent apart from sync_start.

Test Plan:
- Reset, then valid=4'b0001, ch0 half_period=3 -> 1 clk after valid, c[0]=1 and rise[0]=1; c[0] pattern 111000 repeating; fall[0] pulses 3 cycles after each rise; other channels stay 0.
- ch1 half_period=0 and half_period=1, valid[1]=1 -> c[1] toggles every cycle (period 2) in both cases; rise/fall alternate each cycle.
- ch0 half_period=4, drop valid[0] 1 cycle after a rise -> c[0] stays high 4 cycles total, then low 4 cycles, then IDLE with running[0]=0; no pulse shorter than 4.
- ch2 running with half_period=5; change it to 2 mid-HIGH -> current high and low phases stay 5 cycles; the next high phase is 2 cycles.
- ch0 half_period=3 and ch1 half_period=5 both running out of phase; pulse sync_start -> the next cycle both have c=1 with cnt=0; rising edges coincide every 30 cycles thereafter.
- Assert rst_n=0 mid-HIGH on all channels -> the next cycle all outputs are 0 and running=0; after release with valid still 1, restart 1 clk later with rise=1.

Source files
------------

// File: rtl/clk_gen_multi.sv
// Multi-channel gated clock-enable generator: each channel emits a 50%-duty divided
// waveform with registered rise/fall strobes, whole-phase stop and shared phase-aligned restart.
module clk_gen_multi #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DIV_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       valid,
    input  logic [CHANNELS*DIV_W-1:0] half_period,
    input  logic                      sync_start,
    output logic [CHANNELS-1:0]       c,
    output logic [CHANNELS-1:0]       rise,
    output logic [CHANNELS-1:0]       fall,
    output logic [CHANNELS-1:0]       running
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2
    } state_e;

    state_e              r_state   [CHANNELS];
    state_e              w_state_d [CHANNELS];
    logic [DIV_W-1:0]    r_cnt     [CHANNELS];
    logic [DIV_W-1:0]    w_cnt_d   [CHANNELS];
    logic [DIV_W-1:0]    r_hp      [CHANNELS];
    logic [DIV_W-1:0]    w_hp_d    [CHANNELS];
    logic [DIV_W-1:0]    w_hp_in   [CHANNELS];
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic [CHANNELS-1:0] w_rise_d;
    logic [CHANNELS-1:0] w_fall_d;
    logic [CHANNELS-1:0] w_last;

    // A programmed half-period of zero behaves as one.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_hp_in[i] = half_period[i*DIV_W +: DIV_W];
            if (w_hp_in[i] == '0) begin
                w_hp_in[i] = DIV_W'(1);
            end
        end
    end

    always_comb begin
        w_rise_d = '0;
        w_fall_d = '0;
        w_last   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_state_d[i] = r_state[i];
            w_cnt_d[i]   = r_cnt[i];
            w_hp_d[i]    = r_hp[i];
            w_last[i]    = (r_cnt[i] == r_hp[i] - DIV_W'(1));

            if (sync_start && valid[i]) begin
                // Forced restart may cut the current phase; no rise if already high.
                w_state_d[i] = StHigh;
                w_cnt_d[i]   = '0;
                w_hp_d[i]    = w_hp_in[i];
                w_rise_d[i]  = (r_state[i] != StHigh);
            end else begin
                unique case (r_state[i])
                    StIdle: begin
                        if (valid[i]) begin
                            w_state_d[i] = StHigh;
                            w_cnt_d[i]   = '0;
                            w_hp_d[i]    = w_hp_in[i];
                            w_rise_d[i]  = 1'b1;
                        end
                    end
                    StHigh: begin
                        if (w_last[i]) begin
                            w_state_d[i] = StLow;
                            w_cnt_d[i]   = '0;
                            w_fall_d[i]  = 1'b1;
                        end else begin
                            w_cnt_d[i] = r_cnt[i] + DIV_W'(1);
                        end
                    end
                    StLow: begin
                        if (w_last[i]) begin
                            w_cnt_d[i] = '0;
                            if (valid[i]) begin
                                w_state_d[i] = StHigh;
                                w_hp_d[i]    = w_hp_in[i];
                                w_rise_d[i]  = 1'b1;
                            end else begin
                                w_state_d[i] = StIdle;
                            end
                        end else begin
                            w_cnt_d[i] = r_cnt[i] + DIV_W'(1);
                        end
                    end
                    default: begin
                        w_state_d[i] = StIdle;
                        w_cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= StIdle;
                r_cnt[i]   <= '0;
                r_hp[i]    <= '0;
            end
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= w_state_d[i];
                r_cnt[i]   <= w_cnt_d[i];
                r_hp[i]    <= w_hp_d[i];
            end
            r_rise <= w_rise_d;
            r_fall <= w_fall_d;
        end
    end

    always_comb begin
        c       = '0;
        running = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            c[i]       = (r_state[i] == StHigh);
            running[i] = (r_state[i] != StIdle);
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;

endmodule

// File: tb/tb_clk_gen_multi.sv
// Self-checking bench for clk_gen_multi: phase-countdown model compared every cycle,
// plus directed traces with hand-computed waveforms.
module tb_clk_gen_multi;

    localparam int CH = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   valid;
    logic [CH*DW-1:0] half_period;
    logic            sync_start;
    logic [CH-1:0]   c, rise, fall, running;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    clk_gen_multi #(.CHANNELS(CH), .DIV_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (valid),
        .half_period(half_period),
        .sync_start (sync_start),
        .c          (c),
        .rise       (rise),
        .fall       (fall),
        .running    (running)
    );

    always #5 clk = ~clk;

    // Model: each active channel holds a level and the cycles left in its phase.
    logic [CH-1:0] m_c, m_rise, m_fall, m_run;
    int            m_left [CH];
    int            m_hp   [CH];

    function automatic int hp_of(input int ch);
        int v;
        v = int'(half_period[ch*DW +: DW]);
        return (v == 0) ? 1 : v;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            m_rise[i] = 1'b0;
            m_fall[i] = 1'b0;
            if (!rst_n) begin
                m_c[i] = 1'b0; m_run[i] = 1'b0; m_left[i] = 0; m_hp[i] = 0;
            end else if ((sync_start && valid[i]) || (!m_run[i] && valid[i])) begin
                m_rise[i] = !m_c[i];
                m_c[i] = 1'b1; m_run[i] = 1'b1;
                m_hp[i] = hp_of(i); m_left[i] = m_hp[i];
            end else if (m_run[i]) begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    if (m_c[i]) begin
                        m_c[i] = 1'b0; m_fall[i] = 1'b1; m_left[i] = m_hp[i];
                    end else if (valid[i]) begin
                        m_c[i] = 1'b1; m_rise[i] = 1'b1;
                        m_hp[i] = hp_of(i); m_left[i] = m_hp[i];
                    end else begin
                        m_run[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_c",       32'(c),       32'(m_c));
            check("model_rise",    32'(rise),    32'(m_rise));
            check("model_fall",    32'(fall),    32'(m_fall));
            check("model_running", 32'(running), 32'(m_run));
            check("rise_fall_excl", 32'(rise & fall), 32'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hp(input int ch, input int v);
        half_period[ch*DW +: DW] = DW'(v);
    endtask

    task automatic wait_idle(input int ch);
        int n;
        n = 0;
        while (running[ch] && n < 40) begin
            cyc();
            n++;
        end
        check("idle_timeout", 32'(running[ch]), 32'd0);
    endtask

    logic [15:0] tr_c, tr_r, tr_f;
    int          coinc;

    initial begin
        rst_n = 1'b0; valid = '0; half_period = '0; sync_start = 1'b0;
        repeat (3) cyc();
        check("reset_c",   32'(c),       32'd0);
        check("reset_run", 32'(running), 32'd0);
        chk_en = 1'b1;

        // Channel 0, half-period 3.
        rst_n = 1'b1; set_hp(0, 3); valid = 4'b0001;
        cyc();
        check("t1_start_c",    32'(c),    32'h1);
        check("t1_start_rise", 32'(rise), 32'h1);
        tr_c = '0; tr_f = '0;
        for (int k = 0; k < 12; k++) begin
            tr_c = {tr_c[14:0], c[0]};
            tr_f = {tr_f[14:0], fall[0]};
            check("t1_others", 32'(c[3:1]), 32'd0);
            cyc();
        end
        check("t1_trace_c",    32'(tr_c[11:0]), 32'b111000111000);
        check("t1_trace_fall", 32'(tr_f[11:0]), 32'b000100000100);
        valid = '0;
        wait_idle(0);

        // Channel 1, half-period 0 then 1: toggles every cycle.
        for (int h = 0; h < 2; h++) begin
            set_hp(1, h); valid = 4'b0010;
            cyc();
            tr_c = '0; tr_r = '0; tr_f = '0;
            for (int k = 0; k < 6; k++) begin
                tr_c = {tr_c[14:0], c[1]};
                tr_r = {tr_r[14:0], rise[1]};
                tr_f = {tr_f[14:0], fall[1]};
                cyc();
            end
            check("t2_trace_c",    32'(tr_c[5:0]), 32'b101010);
            check("t2_trace_rise", 32'(tr_r[5:0]), 32'b101010);
            check("t2_trace_fall", 32'(tr_f[5:0]), 32'b010101);
            valid = '0;
            wait_idle(1);
        end

        // Channel 0, half-period 4, valid dropped right after the rise.
        set_hp(0, 4); valid = 4'b0001;
        cyc();
        valid = '0;
        tr_c = '0; tr_r = '0;
        for (int k = 0; k < 10; k++) begin
            tr_c = {tr_c[14:0], c[0]};
            tr_r = {tr_r[14:0], running[0]};
            cyc();
        end
        check("t3_trace_c",   32'(tr_c[9:0]), 32'b1111000000);
        check("t3_trace_run", 32'(tr_r[9:0]), 32'b1111111100);

        // Channel 2, half-period 5 changed to 2 mid-high.
        set_hp(2, 5); valid = 4'b0100;
        cyc();
        tr_c = '0;
        for (int k = 0; k < 14; k++) begin
            tr_c = {tr_c[14:0], c[2]};
            if (k == 1) set_hp(2, 2);
            cyc();
        end
        check("t4_trace_c", 32'(tr_c[13:0]), 32'b11111000001100);
        valid = '0;
        wait_idle(2);

        // Channels 0 and 1 out of phase, then phase-aligned by sync_start.
        set_hp(0, 3); set_hp(1, 5); valid = 4'b0001;
        repeat (2) cyc();
        valid = 4'b0011;
        repeat (4) cyc();
        sync_start = 1'b1;
        cyc();
        sync_start = 1'b0;
        check("t5_sync_c", 32'(c[1:0]), 32'b11);
        coinc = 0;
        for (int k = 1; k < 30; k++) begin
            cyc();
            if (rise[0] && rise[1]) coinc++;
        end
        check("t5_no_early_coinc", 32'(coinc), 32'd0);
        cyc();
        check("t5_coinc_30", 32'(rise[1:0]), 32'b11);

        // Reset mid-high on all channels, then restart.
        set_hp(2, 4); set_hp(3, 4); set_hp(0, 4); set_hp(1, 4);
        valid = 4'b1111; sync_start = 1'b1;
        cyc();
        sync_start = 1'b0;
        cyc();
        check("t6_pre_c", 32'(c), 32'hf);
        rst_n = 1'b0;
        cyc();
        check("t6_rst_c",    32'(c),       32'd0);
        check("t6_rst_rise", 32'(rise),    32'd0);
        check("t6_rst_fall", 32'(fall),    32'd0);
        check("t6_rst_run",  32'(running), 32'd0);
        rst_n = 1'b1;
        cyc();
        check("t6_restart_c",    32'(c),       32'hf);
        check("t6_restart_rise", 32'(rise),    32'hf);
        check("t6_restart_run",  32'(running), 32'hf);
        valid = '0;
        repeat (12) cyc();

        @(posedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
